// File: rtl/energy_pkg.sv
// Shared types and constants for the energy sample scheduler.
// Combinational helpers only; no timing or flow control of its own.
package energy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_e;

  localparam int CH_SOLAR = 0;
  localparam int CH_WIND  = 1;
  localparam int CH_BATT  = 2;
  localparam int CH_LOAD  = 3;

  // Channel index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/energy_sample_scheduler_if.sv
// Collector-side conversion handshake plus the tagged sample stream.
// master = scheduler, slave = collector / downstream consumer.
interface energy_sample_scheduler_if
  import energy_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [CH_W-1:0]   sel;
  logic              conv_start;
  logic              conv_done;
  logic [DATA_W-1:0] conv_data;
  logic              sample_valid;
  logic [CH_W-1:0]   sample_ch;
  logic [DATA_W-1:0] sample_data;

  modport master (
    output sel, conv_start, sample_valid, sample_ch, sample_data,
    input  conv_done, conv_data
  );

  modport slave (
    input  sel, conv_start, sample_valid, sample_ch, sample_data,
    output conv_done, conv_data
  );

endinterface

// File: rtl/energy_sample_scheduler_period_tick_gen.sv
// Free-running down-counter raising a one-cycle tick every max(period,1) cycles.
// Tick is combinational from the count; no backpressure, ticks are never held.
module period_tick_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] reload;
  logic [PERIOD_W-1:0] cur;
  logic                first_q, first_d;

  // The first cycle after reset behaves as if the count had been loaded with
  // the reload value, keeping the reset value of the counter a constant.
  always_comb begin
    reload  = (period == '0) ? '0 : period - PERIOD_W'(1);
    cur     = first_q ? reload : cnt_q;
    tick    = (cur == '0);
    cnt_d   = tick ? reload : cur - PERIOD_W'(1);
    first_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/energy_sample_scheduler.sv
// Round scheduler: per period tick, converts each enabled channel in order and publishes tagged samples.
// conv_done at t gives sample_valid at t+1; no backpressure, a tick arriving mid-round is dropped and flagged.
module energy_sample_scheduler
  import energy_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [PERIOD_W-1:0]   period,
  energy_sample_scheduler_if.master bus,
  output logic                  round_done,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [CH_W:0] IDX_END  = (CH_W+1)'(NUM_CH);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  logic tick;

  period_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .period (period),
    .tick   (tick)
  );

  state_e            state_q, state_d;
  logic [CH_W:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [CH_W-1:0]   sch_q, sch_d;
  logic [DATA_W-1:0] sdat_q, sdat_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              terr_q, terr_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    sel_d     = sel_q;
    tcnt_d    = tcnt_q;
    sch_d     = sch_q;
    sdat_d    = sdat_q;
    busy_d    = busy_q;
    terr_d    = terr_q;
    overrun_d = overrun_q | (tick && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          mask_d  = ch_enable;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx_q == IDX_END) begin
          state_d = ST_DONE;
        end else if (mask_q[idx_q[CH_W-1:0]]) begin
          sel_d   = idx_q[CH_W-1:0];
          state_d = ST_START;
        end else begin
          idx_d = idx_q + (CH_W+1)'(1);
        end
      end
      ST_START: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Sample tag/data update on entry to STORE so they are valid with the pulse.
        if (bus.conv_done) begin
          sch_d   = idx_q[CH_W-1:0];
          sdat_d  = bus.conv_data;
          state_d = ST_STORE;
        end else if (tcnt_q == TMO_LAST) begin
          terr_d  = 1'b1;
          idx_d   = idx_q + (CH_W+1)'(1);
          state_d = ST_SCAN;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ST_STORE: begin
        idx_d   = idx_q + (CH_W+1)'(1);
        state_d = ST_SCAN;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      sel_q     <= '0;
      tcnt_q    <= '0;
      sch_q     <= '0;
      sdat_q    <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      sel_q     <= sel_d;
      tcnt_q    <= tcnt_d;
      sch_q     <= sch_d;
      sdat_q    <= sdat_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      terr_q    <= terr_d;
    end
  end

  // Pulses decode straight from the registered state, so they are clean and reset low.
  assign bus.conv_start   = (state_q == ST_START);
  assign bus.sample_valid = (state_q == ST_STORE);
  assign bus.sel          = sel_q;
  assign bus.sample_ch    = sch_q;
  assign bus.sample_data  = sdat_q;
  assign round_done       = (state_q == ST_DONE);
  assign busy             = busy_q;
  assign overrun          = overrun_q;
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_energy_sample_scheduler.sv
// Bench for energy_sample_scheduler: collector model plus expected-sample queue checked on sample_valid.
module tb_energy_sample_scheduler;
  import energy_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 8;
  localparam int PERIOD_W = 16;
  localparam int TIMEOUT  = 8;
  localparam int CH_W     = ch_w(NUM_CH);

  typedef struct {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] d;
  } smp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_CH-1:0]   ch_enable = '0;
  logic [PERIOD_W-1:0] period = '0;
  logic                round_done, busy, overrun, timeout_err;

  energy_sample_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  energy_sample_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_enable   (ch_enable),
    .period      (period),
    .bus         (bus),
    .round_done  (round_done),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int                n_cmp = 0;
  int                n_fail = 0;
  smp_t              exp_q[$];
  int                lat = 3;
  logic [NUM_CH-1:0] dead = '0;
  logic [NUM_CH-1:0] exp_mask = '0;
  int                n_start, n_sample, cyc, pend;
  int                start_cyc[NUM_CH];
  logic [CH_W-1:0]   pend_ch;

  // Collector model and sample monitor share one process so the prior-cycle
  // conv_done value is read before it is updated.
  initial begin
    smp_t e;
    bus.conv_done = 1'b0;
    bus.conv_data = '0;
    pend = 0;
    pend_ch = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        bus.conv_done = 1'b0;
        n_start = 0;
        n_sample = 0;
        cyc = 0;
      end else begin
        cyc++;
        if (bus.sample_valid) begin
          n_sample++;
          n_cmp++;
          if (bus.conv_done !== 1'b1) begin
            n_fail++;
            $display("FAIL sample_latency: conv_done prior cycle=%b required 1", bus.conv_done);
          end
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sample_unexpected: ch=%0d data=%h required no sample",
                     bus.sample_ch, bus.sample_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.sample_ch !== e.ch || bus.sample_data !== e.d) begin
              n_fail++;
              $display("FAIL sample_tag: ch=%0d data=%h required ch=%0d data=%h",
                       bus.sample_ch, bus.sample_data, e.ch, e.d);
            end
          end
        end
        if (bus.conv_start) begin
          n_cmp++;
          if (exp_mask[bus.sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL sel_enabled: sel=%0d mask=%b required enabled channel", bus.sel, exp_mask);
          end
          n_start++;
          start_cyc[bus.sel] = cyc;
        end
        bus.conv_done = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.conv_done = 1'b1;
            bus.conv_data = DATA_W'(8'h10) + DATA_W'(pend_ch);
          end
        end
        if (bus.conv_start && !dead[bus.sel]) begin
          pend = lat;
          pend_ch = bus.sel;
        end
      end
    end
  end

  task automatic start_cfg(input int p, input logic [NUM_CH-1:0] en, input int l,
                           input logic [NUM_CH-1:0] dd);
    rst = 1'b1;
    @(negedge clk);
    period = PERIOD_W'(p);
    ch_enable = en;
    lat = l;
    dead = dd;
    exp_mask = en;
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      if (en[i] && !dd[i]) exp_q.push_back('{ch: CH_W'(i), d: DATA_W'(8'h10 + i)});
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Expected number of cycles from reset release to the round_done cycle.
  function automatic int exp_len(input int p, input logic [NUM_CH-1:0] en,
                                 input logic [NUM_CH-1:0] dd, input int l);
    int n;
    n = (p == 0) ? 1 : p;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!en[i])     n += 1;
      else if (dd[i]) n += 2 + TIMEOUT;
      else            n += 3 + l;
    end
    return n + 1;
  endfunction

  task automatic run_round(input logic do_tog, input logic [NUM_CH-1:0] tog,
                           output int done_k, output int busy_k);
    done_k = -1;
    busy_k = -1;
    rst = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      #1;
      if (busy && busy_k < 0) begin
        busy_k = k;
        if (do_tog) ch_enable = tog;
      end
      if (round_done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic check_round_end(input string nm, input int done_k, input int exp_k);
    n_cmp++;
    if (done_k !== exp_k) begin
      n_fail++;
      $display("FAIL %s_round_done_cycle: got %0d required %0d", nm, done_k, exp_k);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_missing_samples: %0d left required 0", nm, exp_q.size());
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || round_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_done: busy=%b round_done=%b required 0 0", nm, busy, round_done);
    end
  endtask

  task automatic test_reset();
    int done_k, busy_k, k;
    logic [CH_W+1+1+CH_W+DATA_W+4-1:0] v;
    start_cfg(20, 4'b1100, 3, '0);
    rst = 1'b0;
    k = 0;
    while (bus.conv_start !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    v = {bus.sel, bus.conv_start, bus.sample_valid, bus.sample_ch, bus.sample_data,
         round_done, busy, overrun, timeout_err};
    n_cmp++;
    if (k >= 200 || v !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h (wait %0d) required 0", v, k);
    end
    start_cfg(20, 4'b1100, 3, '0);
    run_round(1'b0, '0, done_k, busy_k);
    n_cmp++;
    if (busy_k !== 20) begin
      n_fail++;
      $display("FAIL reset_first_tick: busy at %0d required 20", busy_k);
    end
    check_round_end("reset", done_k, exp_len(20, 4'b1100, '0, 3));
  endtask

  task automatic test_full_round();
    int done_k, busy_k;
    start_cfg(100, 4'b1111, 3, '0);
    run_round(1'b0, '0, done_k, busy_k);
    n_cmp++;
    if (busy_k !== 100 || n_start !== 4 || n_sample !== 4) begin
      n_fail++;
      $display("FAIL full_counts: tick %0d starts %0d samples %0d required 100 4 4",
               busy_k, n_start, n_sample);
    end
    n_cmp++;
    if (bus.sample_ch !== CH_W'(CH_LOAD) || bus.sample_data !== 8'h13) begin
      n_fail++;
      $display("FAIL full_hold: ch=%0d data=%h required 3 13", bus.sample_ch, bus.sample_data);
    end
    n_cmp++;
    if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags: overrun=%b timeout_err=%b required 0 0", overrun, timeout_err);
    end
    check_round_end("full", done_k, 125);
  endtask

  task automatic test_sparse();
    int done_k, busy_k;
    start_cfg(100, 4'b1010, 3, '0);
    run_round(1'b0, '0, done_k, busy_k);
    n_cmp++;
    if (n_start !== 2) begin
      n_fail++;
      $display("FAIL sparse_starts: got %0d required 2", n_start);
    end
    check_round_end("sparse", done_k, 115);
  endtask

  task automatic test_timeout();
    int done_k, busy_k;
    start_cfg(50, 4'b1111, 3, 4'b0100);
    run_round(1'b0, '0, done_k, busy_k);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_flag: got %b required 1", timeout_err);
    end
    n_cmp++;
    if (start_cyc[3] - start_cyc[2] !== 2 + TIMEOUT || n_sample !== 3) begin
      n_fail++;
      $display("FAIL timeout_skip: gap %0d samples %0d required %0d 3",
               start_cyc[3] - start_cyc[2], n_sample, 2 + TIMEOUT);
    end
    check_round_end("timeout", done_k, 79);
  endtask

  task automatic test_overrun();
    int done_k, busy_k;
    start_cfg(10, 4'b1111, 5, '0);
    run_round(1'b0, '0, done_k, busy_k);
    n_cmp++;
    if (overrun !== 1'b1 || n_start !== 4) begin
      n_fail++;
      $display("FAIL overrun_flag: overrun=%b starts=%0d required 1 4", overrun, n_start);
    end
    check_round_end("overrun", done_k, 43);
  endtask

  task automatic test_period_zero_empty();
    int done_k, busy_k;
    start_cfg(0, 4'b0000, 3, '0);
    run_round(1'b0, '0, done_k, busy_k);
    n_cmp++;
    if (busy_k !== 1 || n_start !== 0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_round: tick %0d starts %0d overrun %b required 1 0 1",
               busy_k, n_start, overrun);
    end
    check_round_end("empty", done_k, 6);
  endtask

  task automatic test_enable_change();
    int done_k, busy_k;
    start_cfg(30, 4'b0101, 3, '0);
    run_round(1'b1, 4'b1010, done_k, busy_k);
    n_cmp++;
    if (n_start !== 2 || n_sample !== 2) begin
      n_fail++;
      $display("FAIL enable_change: starts %0d samples %0d required 2 2", n_start, n_sample);
    end
    check_round_end("enchg", done_k, 45);
  endtask

  initial begin
    test_reset();
    test_full_round();
    test_sparse();
    test_timeout();
    test_overrun();
    test_period_zero_empty();
    test_enable_change();
    rst = 1'b1;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/energy_sample_scheduler.md
Name: energy_sample_scheduler

Overview:
- Sequences the shared sample/convert datapath across several energy-source channels (solar, wind, battery, load).
- A programmable period timer starts each sampling round. Enabled channels are served in ascending index order.
- For each channel the block steers the input mux, fires a conversion start pulse, waits for done with a timeout, then republishes the result tagged with its channel number.
- Sits between the top-level input pins and the data collector; downstream logging and display logic consume its tagged sample stream.

Parameters:
NUM_CH, 4, number of source channels (2..8)
DATA_W, 8, conversion result width
PERIOD_W, 16, width of round period register
TIMEOUT, 255, max cycles waited for conv_done per channel (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ch_enable  in  NUM_CH  per-channel enable; sampled only at round start
period  in  PERIOD_W  cycles between round-start ticks; 0 is treated as 1
sel  out  clog2(NUM_CH)  mux select to the collector input
conv_start  out  1  single-cycle conversion start pulse
conv_done  in  1  collector result ready, single-cycle
conv_data  in  DATA_W  collector result, valid when conv_done=1
sample_valid  out  1  single-cycle pulse, new tagged sample
sample_ch  out  clog2(NUM_CH)  channel of the sample
sample_data  out  DATA_W  sample value
round_done  out  1  single-cycle pulse at end of each round
busy  out  1  high while a round is in progress
overrun  out  1  sticky: a tick arrived while busy
timeout_err  out  1  sticky: a channel timed out

Behaviour:
- Reset (async, while rst=1):
  - sel, sample_ch, sample_data = 0; all pulses = 0; busy, overrun, timeout_err = 0.
  - FSM = IDLE; period counter loads max(period,1)-1.
- Period counter:
  - Free-running down-counter. At 0 it raises an internal tick and reloads max(period,1)-1.
  - A period change takes effect at the next reload.
- FSM states: IDLE, SCAN, START, WAIT, STORE, DONE.
- IDLE:
  - On tick: latch mask <= ch_enable, set idx=0, go to SCAN; busy=1 from the next cycle.
- SCAN (one cycle per index examined):
  - If idx==NUM_CH: go to DONE.
  - Else if mask[idx]=1: sel<=idx, go to START.
  - Else idx++ and stay in SCAN.
  - An empty mask therefore yields DONE after NUM_CH+1 SCAN cycles, with no conversions.
- START:
  - conv_start=1 for exactly this cycle; sel is stable from START until leaving WAIT.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - If conv_done=1: capture conv_data and go to STORE.
  - Else if timeout counter == TIMEOUT-1: set timeout_err, idx++, go to SCAN; no sample_valid is issued.
  - Else increment the timeout counter.
  - conv_done in any state other than WAIT is ignored.
- STORE:
  - sample_valid=1, sample_ch=idx, sample_data=captured value; idx++; go to SCAN.
  - Latency: conv_done at cycle t gives sample_valid at t+1.
  - sample_ch and sample_data hold until the next STORE.
- DONE:
  - round_done=1 for one cycle; busy=0 from the next cycle; go to IDLE.
- Tick in any state other than IDLE:
  - overrun set (sticky); the tick is dropped and the round continues unaffected.
  - A tick coinciding with the DONE cycle also counts as overrun. No queued round.
- ch_enable changes mid-round have no effect until the next round.
- Sticky flags clear only on rst.
- Reset asserted mid-round: round aborts immediately, no round_done; outputs take reset values.

Decomposition:
- Shared package energy_pkg:
  - FSM state enum.
  - CH_W = clog2(NUM_CH) helper.
  - Channel index constants CH_SOLAR=0, CH_WIND=1, CH_BATT=2, CH_LOAD=3.
- One natural sub-module: period_tick_gen (down-counter, reload, tick output).

Test Plan:
- Reset check: rst high mid-WAIT -> all outputs 0 and busy=0 while rst high; after release, first tick lands at cycle period.
- Full round: period=100, ch_enable=4'b1111, collector model returns done 3 cycles after start with data 8'h10+ch -> four sample_valid pulses, ch 0..3, data 10,11,12,13; round_done once; busy drops before the next tick.
- Sparse mask: ch_enable=4'b1010 -> samples only on ch1 and ch3; sel never 0 or 2 during START/WAIT.
- Timeout: ch2 never answers, TIMEOUT=8 -> ch2 skipped after 8 WAIT cycles, timeout_err=1, ch3 still sampled, round_done asserted.
- Overrun: period=10, done latency 5, all channels enabled -> overrun=1; no extra round started while busy; samples remain in order.
- Edge cases:
  - period=0 -> tick every cycle.
  - ch_enable=0 -> round_done with no conv_start.
  - ch_enable toggled mid-round -> current round unchanged.
